// File: rtl/sr04_uart_frame_sched.sv
// Frame scheduler for the two HC-SR04 channels.
// Each channel's 8-bit distance is captured on its done strobe. The two channels
// share one UART TX, with round-robin arbitration between them. The granted value
// is sent as a 7-byte ASCII frame: "X=ddd\r\n" or "Y=ddd\r\n".
//
// TX handshake (the only handshake on this block):
//   - tx_start pulses for one cycle. tx_data is valid in that cycle and is held
//     until the next tx_start.
//   - After the pulse the scheduler waits for tx_busy to rise, then waits for it
//     to fall. The byte then counts as done.
//   - If tx_busy never rises within BUSY_TIMEOUT cycles of the tx_start cycle,
//     the byte is taken as accepted anyway, so a missing TX never stalls frames.
module sr04_uart_frame_sched #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 100
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] dist_x,
    input  logic       done_x,
    input  logic [7:0] dist_y,
    input  logic       done_y,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       frame_active,
    output logic       pending_x,
    output logic       pending_y,
    output logic [7:0] drop_cnt,
    output logic [2:0] dbg_state
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [7:0]       TO_LAST  = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT_H = 3'd2,
        S_WAIT_L = 3'd3,
        S_NEXT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       hold_x_q, hold_x_d;
    logic [7:0]       hold_y_q, hold_y_d;
    logic             pend_x_q, pend_x_d;
    logic             pend_y_q, pend_y_d;
    logic [7:0]       drop_q, drop_d;
    logic             last_grant_q, last_grant_d;   // 1 = Y was granted last
    logic             frame_ch_q, frame_ch_d;       // 1 = current frame is Y
    logic [7:0]       frame_val_q, frame_val_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       to_q, to_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             frame_active_q, frame_active_d;

    logic             grant_x, grant_y;
    logic             drop_x, drop_y;
    logic [8:0]       drop_sum;
    logic [7:0]       dig_h, dig_t, dig_o;
    logic [7:0]       frame_byte;

    // Decimal digits of the frame value, leading zeros kept
    always_comb begin
        dig_h = frame_val_q / 8'd100;
        dig_t = (frame_val_q / 8'd10) % 8'd10;
        dig_o = frame_val_q % 8'd10;
    end

    // Byte selected by the frame index
    always_comb begin
        frame_byte = 8'h0A;
        case (idx_q)
            3'd0:    frame_byte = frame_ch_q ? 8'h59 : 8'h58;
            3'd1:    frame_byte = 8'h3D;
            3'd2:    frame_byte = 8'h30 + dig_h;
            3'd3:    frame_byte = 8'h30 + dig_t;
            3'd4:    frame_byte = 8'h30 + dig_o;
            3'd5:    frame_byte = 8'h0D;
            default: frame_byte = 8'h0A;
        endcase
    end

    // Next-state: arbitration, frame sequencing, capture and drop counting
    always_comb begin
        state_d        = state_q;
        hold_x_d       = hold_x_q;
        hold_y_d       = hold_y_q;
        pend_x_d       = pend_x_q;
        pend_y_d       = pend_y_q;
        last_grant_d   = last_grant_q;
        frame_ch_d     = frame_ch_q;
        frame_val_d    = frame_val_q;
        idx_d          = idx_q;
        to_d           = to_q;
        gap_d          = gap_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        frame_active_d = frame_active_q;
        grant_x        = 1'b0;
        grant_y        = 1'b0;

        if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (gap_q == '0) begin
                    // On a tie the channel that was not granted last wins
                    grant_x = pend_x_q && (!pend_y_q || last_grant_q);
                    grant_y = pend_y_q && (!pend_x_q || !last_grant_q);
                    if (grant_x || grant_y) begin
                        frame_ch_d     = grant_y;
                        frame_val_d    = grant_y ? hold_y_q : hold_x_q;
                        last_grant_d   = grant_y;
                        frame_active_d = 1'b1;
                        idx_d          = 3'd0;
                        state_d        = S_START;
                    end
                end
            end
            S_START: begin
                tx_data_d  = frame_byte;
                tx_start_d = 1'b1;
                to_d       = 8'd0;
                state_d    = S_WAIT_H;
            end
            S_WAIT_H: begin
                if (tx_busy) begin
                    state_d = S_WAIT_L;
                end else if (to_q == TO_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            S_WAIT_L: begin
                if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q != 3'd6) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_START;
                end else begin
                    idx_d          = 3'd0;
                    frame_active_d = 1'b0;
                    gap_d          = GAP_LOAD;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                idx_d          = 3'd0;
                frame_active_d = 1'b0;
                state_d        = S_IDLE;
            end
        endcase

        // A done on the grant edge re-arms pending and is not a drop
        drop_x = done_x && pend_x_q && !grant_x;
        drop_y = done_y && pend_y_q && !grant_y;

        if (grant_x) pend_x_d = 1'b0;
        if (grant_y) pend_y_d = 1'b0;
        if (done_x) begin
            hold_x_d = dist_x;
            pend_x_d = 1'b1;
        end
        if (done_y) begin
            hold_y_d = dist_y;
            pend_y_d = 1'b1;
        end

        drop_sum = {1'b0, drop_q} + 9'(drop_x) + 9'(drop_y);
        drop_d   = drop_sum[8] ? 8'd255 : drop_sum[7:0];
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q        <= S_IDLE;
            hold_x_q       <= 8'd0;
            hold_y_q       <= 8'd0;
            pend_x_q       <= 1'b0;
            pend_y_q       <= 1'b0;
            drop_q         <= 8'd0;
            last_grant_q   <= 1'b1;
            frame_ch_q     <= 1'b0;
            frame_val_q    <= 8'd0;
            idx_q          <= 3'd0;
            to_q           <= 8'd0;
            gap_q          <= '0;
            tx_data_q      <= 8'd0;
            tx_start_q     <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_x_q       <= hold_x_d;
            hold_y_q       <= hold_y_d;
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            drop_q         <= drop_d;
            last_grant_q   <= last_grant_d;
            frame_ch_q     <= frame_ch_d;
            frame_val_q    <= frame_val_d;
            idx_q          <= idx_d;
            to_q           <= to_d;
            gap_q          <= gap_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign frame_active = frame_active_q;
    assign pending_x    = pend_x_q;
    assign pending_y    = pend_y_q;
    assign drop_cnt     = drop_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sr04_uart_frame_sched.sv
// Bench for sr04_uart_frame_sched.
// The reference model tracks pending values per channel and round-robin order.
// On each grant it pushes the 7 expected ASCII bytes onto exp_q. A monitor pops
// one byte per tx_start pulse and compares it with tx_data.
module tb_sr04_uart_frame_sched;

    localparam int BUSY_TIMEOUT = 16;
    localparam int GAP_CYCLES   = 100;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [7:0] dist_x = 8'd0;
    logic       done_x = 1'b0;
    logic [7:0] dist_y = 8'd0;
    logic       done_y = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       frame_active;
    logic       pending_x;
    logic       pending_y;
    logic [7:0] drop_cnt;
    logic [2:0] dbg_state;

    sr04_uart_frame_sched #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .dist_x      (dist_x),
        .done_x      (done_x),
        .dist_y      (dist_y),
        .done_y      (done_y),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .frame_active(frame_active),
        .pending_x   (pending_x),
        .pending_y   (pending_y),
        .drop_cnt    (drop_cnt),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    bit         m_pend[2];
    logic [7:0] m_val[2];
    int         m_last = 1;
    int         m_drop = 0;
    int         m_ch;
    bit         cap_v[2];
    logic [7:0] cap_d[2];

    // Monitor bookkeeping
    int  cyc = 0;
    bit  fa_prev = 1'b0;
    int  fall_cyc = -1;
    int  last_gap = -1;
    int  start_cnt = 0;
    int  last_start_cyc = 0;
    bit  prev_start = 1'b0;
    bit  lat_armed = 1'b0;
    int  lat_done_cyc = 0;
    bit  timeout_mode = 1'b0;

    // TX model controls
    bit  busy_en = 1'b1;
    int  busy_len = 20;

    task automatic push_frame(input int ch, input logic [7:0] v);
        int n;
        n = int'(v);
        exp_q.push_back(ch == 1 ? 8'h59 : 8'h58);
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'(48 + n / 100));
        exp_q.push_back(8'(48 + (n / 10) % 10));
        exp_q.push_back(8'(48 + n % 10));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Reference model + scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_p) begin
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            m_last    = 1;
            m_drop    = 0;
            cap_v[0]  = 1'b0;
            cap_v[1]  = 1'b0;
            exp_q.delete();
            fa_prev    = 1'b0;
            fall_cyc   = -1;
            start_cnt  = 0;
            prev_start = 1'b0;
            lat_armed  = 1'b0;
        end else begin
            // A grant happened on the last edge: decide from pre-edge pending state
            if (frame_active && !fa_prev) begin
                if (!m_pend[0] && !m_pend[1]) begin
                    chk("grant_without_pending", 1, 0);
                end else begin
                    if (m_pend[0] && m_pend[1]) m_ch = (m_last == 1) ? 0 : 1;
                    else                        m_ch = m_pend[1] ? 1 : 0;
                    push_frame(m_ch, m_val[m_ch]);
                    m_pend[m_ch] = 1'b0;
                    m_last       = m_ch;
                end
                if (fall_cyc >= 0) begin
                    last_gap = cyc - fall_cyc;
                    chk("gap_min", int'(last_gap >= GAP_CYCLES + 1), 1);
                end
                start_cnt = 0;
            end
            if (!frame_active && fa_prev) begin
                chk("frame_len", start_cnt, 7);
                chk("busy_low_at_frame_end", int'(tx_busy), 0);
                fall_cyc = cyc;
            end
            // Results presented before the last edge are now captured
            for (int c = 0; c < 2; c++) begin
                if (cap_v[c]) begin
                    if (m_pend[c] && m_drop < 255) m_drop = m_drop + 1;
                    m_pend[c] = 1'b1;
                    m_val[c]  = cap_d[c];
                end
            end
            fa_prev  = frame_active;
            cap_v[0] = done_x;
            cap_d[0] = dist_x;
            cap_v[1] = done_y;
            cap_d[1] = dist_y;

            chk("pending_x", int'(pending_x), int'(m_pend[0]));
            chk("pending_y", int'(pending_y), int'(m_pend[1]));
            chk("drop_cnt", int'(drop_cnt), m_drop);

            if (tx_start) begin
                if (exp_q.size() == 0) chk("unexpected_tx_start", 1, 0);
                else                   chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
                chk("start_in_frame", int'(frame_active), 1);
                chk("start_width", int'(prev_start), 0);
                if (timeout_mode && start_cnt > 0)
                    chk("timeout_spacing", cyc - last_start_cyc, BUSY_TIMEOUT + 2);
                if (lat_armed) begin
                    chk("first_start_latency", cyc - lat_done_cyc, 3);
                    lat_armed = 1'b0;
                end
                last_start_cyc = cyc;
                start_cnt      = start_cnt + 1;
            end
            prev_start = tx_start;
        end
    end

    // TX model: busy rises one cycle after tx_start and stays high busy_len cycles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1 && busy_en) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input bit dx, input logic [7:0] vx, input bit dy, input logic [7:0] vy);
        done_x = dx;
        dist_x = vx;
        done_y = dy;
        dist_y = vy;
        tick();
        done_x = 1'b0;
        done_y = 1'b0;
        dist_x = 8'($urandom);
        dist_y = 8'($urandom);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || frame_active || m_pend[0] || m_pend[1] ||
                cap_v[0] || cap_v[1]) && b < 20000) begin
            tick();
            b++;
        end
        chk("drain_timeout", int'(b < 20000), 1);
        repeat (GAP_CYCLES + 2) tick();
    endtask

    task automatic wait_frame(input int min_starts);
        int b;
        b = 0;
        while (!(frame_active && start_cnt >= min_starts) && b < 5000) begin
            tick();
            b++;
        end
        chk("wait_frame_timeout", int'(b < 5000), 1);
    endtask

    // Stimulus
    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_frame_active", int'(frame_active), 0);
        chk("rst_pending_x", int'(pending_x), 0);
        chk("rst_pending_y", int'(pending_y), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_state", int'(dbg_state), 0);
        reset_p = 1'b0;
        repeat (3) tick();

        // Single X frame, latency from done to first tx_start
        busy_en  = 1'b1;
        busy_len = 20;
        lat_armed    = 1'b1;
        lat_done_cyc = cyc + 1;
        pulse(1'b1, 8'd123, 1'b0, 8'd0);
        drain();

        // Tie: X wins first, Y follows after exactly the gap, next tie goes to X again
        busy_len = 3;
        pulse(1'b1, 8'd5, 1'b1, 8'd200);
        drain();
        chk("tie_gap_exact", last_gap, GAP_CYCLES + 1);
        pulse(1'b1, 8'($urandom), 1'b1, 8'($urandom));
        drain();

        // Overwrite of a pending Y during an X frame
        pulse(1'b1, 8'($urandom), 1'b0, 8'd0);
        wait_frame(1);
        pulse(1'b0, 8'd0, 1'b1, 8'd10);
        repeat (3) tick();
        pulse(1'b0, 8'd0, 1'b1, 8'd42);
        chk("overwrite_drop", int'(drop_cnt), 1);
        chk("overwrite_pending_y", int'(pending_y), 1);
        drain();

        // Busy never rises: every byte advances on the timeout
        busy_en      = 1'b0;
        timeout_mode = 1'b1;
        pulse(1'b1, 8'($urandom), 1'b0, 8'd0);
        drain();
        timeout_mode = 1'b0;
        busy_en      = 1'b1;

        // Reset in the middle of byte 3, then a fresh frame from byte 0
        busy_len = 6;
        pulse(1'b1, 8'($urandom), 1'b0, 8'd0);
        wait_frame(1);
        pulse(1'b0, 8'd0, 1'b1, 8'($urandom));
        wait_frame(4);
        reset_p = 1'b1;
        #1;
        chk("midrst_tx_start", int'(tx_start), 0);
        chk("midrst_pending_x", int'(pending_x), 0);
        chk("midrst_pending_y", int'(pending_y), 0);
        chk("midrst_drop_cnt", int'(drop_cnt), 0);
        chk("midrst_frame_active", int'(frame_active), 0);
        chk("midrst_tx_data", int'(tx_data), 0);
        repeat (2) tick();
        reset_p = 1'b0;
        tick();
        pulse(1'b1, 8'd255, 1'b0, 8'd0);
        drain();

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            busy_len = $urandom_range(1, 20);
            for (int c = 0; c < int'($urandom_range(20, 200)); c++) begin
                pulse(($urandom_range(0, 39) == 0), 8'($urandom),
                      ($urandom_range(0, 39) == 0), 8'($urandom));
            end
            drain();
        end

        // Drop counter saturation
        busy_len = 2;
        for (int i = 0; i < 320; i++) begin
            pulse((i % 60) == 0, 8'($urandom), 1'b1, 8'($urandom));
        end
        chk("drop_saturated", int'(drop_cnt), 255);
        for (int i = 0; i < 20; i++) begin
            pulse(1'b0, 8'd0, 1'b1, 8'($urandom));
        end
        chk("drop_held", int'(drop_cnt), 255);
        drain();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
